ser_arbiter: RTL and testbench
==============================

SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 Parameter BIT, 8, word width of the serialized stream (used only for documentation and bench; no datapath inside).
REQ-002 Parameter NDATA, 3, words per packet loaded into the external parallel-in/serial-out register; legal range is 1 or more.
REQ-003 Parameter NREQ, 4, number of requesters; legal range is 2 or more.
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  reset; synchronous and active-high.
REQ-006 i_req  in  NREQ  per-requester packet-pending flag; the requester holds its packet on the data mux input while asserted.
REQ-007 o_gnt  out  NREQ  one-hot accept pulse to the winning requester.
REQ-008 o_sel  out  clog2(NREQ)  data-mux select driving the winner's packet into the external register.
REQ-009 o_load  out  1  parallel-load strobe to the external register.
REQ-010 o_shift  out  1  shift strobe to the external register.
REQ-011 o_valid  out  1  the external register's head word is a valid stream beat.
REQ-012 i_ready  in  1  downstream accepts the beat when o_valid and i_ready are both high.
REQ-013 o_last  out  1  the current beat is the final word of the packet.
REQ-014 o_src  out  clog2(NREQ)  index of the requester owning the current packet.

Function
REQ-015 The FSM SHALL have two states: IDLE and SEND.
REQ-016 In IDLE with any i_req set, the block SHALL combinationally assert o_gnt, o_load and o_sel for the round-robin winner in the same cycle, then enter SEND on the next edge with beat counter 0 and o_src equal to the winner.
REQ-017 The round-robin search SHALL start at the pointer and wrap modulo NREQ; on each grant the pointer SHALL become (winner+1) mod NREQ.
REQ-018 In IDLE with no i_req set, o_gnt, o_load and o_shift SHALL be 0, the pointer SHALL hold, and the FSM SHALL stay in IDLE.
REQ-019 In SEND, o_valid SHALL be 1, o_gnt SHALL be 0 and o_load SHALL be 0.
REQ-020 o_last SHALL equal (state==SEND and counter==NDATA-1); with NDATA=1 the first beat SHALL be the last beat.
REQ-021 On a handshake in SEND with a non-last beat, o_shift SHALL be 1 and the counter SHALL increment.
REQ-022 On a last-beat handshake, o_shift SHALL be 1 and the FSM SHALL return to IDLE, giving one idle cycle between packets.
REQ-023 In SEND with i_ready low, all state SHALL hold, o_shift SHALL be 0, and o_valid SHALL stay 1 (no beat is dropped).
REQ-024 i_req changes during SEND SHALL be ignored until the FSM is back in IDLE.
REQ-025 o_sel SHALL hold the winner index in SEND; when not granting in IDLE its value is don't-care, but the implementation SHALL drive 0 there.

Reset
REQ-026 While i_rst is high: state=IDLE, counter=0, pointer=0, o_src=0.
REQ-027 While i_rst is high, o_valid, o_load, o_shift, o_gnt and o_last SHALL be 0 regardless of i_req.
REQ-028 A reset asserted mid-packet SHALL abort the packet without a shift; the aborted requester is not re-granted automatically.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, SEND) and a clog2-based width helper used for the counter, o_sel and o_src.
REQ-030 The round-robin selection SHALL be a sub-module, rr_pick, with inputs request vector and pointer and outputs a one-hot grant, an index and an any-request flag (purely combinational); the FSM, counter and pointer stay in ser_arbiter.

Verification (NREQ=4, NDATA=3, external register modelled in the bench)
REQ-031 Single request: i_req=0010 with i_ready always 1 -> o_gnt=0010 and o_load for 1 cycle, then 3 beats with o_src=1 and o_last on the third, then IDLE.
REQ-032 Fairness: i_req=1111 held -> grant order is 0,1,2,3,0, each packet 3 beats followed by 1 idle cycle.
REQ-033 Backpressure: i_ready low for 5 cycles on beat 2 -> o_valid stays 1, o_shift stays 0, the beat is not repeated or lost, and the word sequence is intact.
REQ-034 Wrap: the pointer is at 3 and i_req=0001 -> requester 0 is granted and the pointer becomes 1.
REQ-035 Reset mid-packet: i_rst during beat 1 -> next cycle IDLE with all strobes 0, and the pointer=0 grant order restarts.
REQ-036 NDATA=1 build: i_req=0100 -> one beat with o_last=1 and o_shift=1, then IDLE.

Source files
------------

// File: rtl/ser_arbiter_pkg.sv
// Shared types and width helper for the serializer arbiter slice.
// Index widths never collapse to zero so single-entry builds still elaborate.
package ser_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ser_arbiter_if.sv
// Requester/stream handshake bundle between the arbiter and its external shift register.
// master = arbiter side, slave = requesters plus downstream sink.
interface ser_arbiter_if
   import ser_arbiter_pkg::*;
#(
   parameter int NREQ = 4
);
   localparam int SW = idx_width(NREQ);

   logic [NREQ-1:0] i_req;
   logic [NREQ-1:0] o_gnt;
   logic [SW-1:0]   o_sel;
   logic            o_load;
   logic            o_shift;
   logic            o_valid;
   logic            i_ready;
   logic            o_last;
   logic [SW-1:0]   o_src;

   modport master (
      input  i_req, i_ready,
      output o_gnt, o_sel, o_load, o_shift, o_valid, o_last, o_src
   );

   modport slave (
      output i_req, i_ready,
      input  o_gnt, o_sel, o_load, o_shift, o_valid, o_last, o_src
   );

endinterface

// File: rtl/ser_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
// Zero latency; no handshake of its own.
module rr_pick
   import ser_arbiter_pkg::*;
#(
   parameter int N = 4,
   parameter int W = idx_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   int          sum;
   logic [W-1:0] pos;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      sum = 0;
      pos = '0;
      for (int i = 0; i < N; i++) begin
         // ptr is always < N, so one subtraction is enough to wrap
         sum = int'(ptr) + i;
         if (sum >= N) sum = sum - N;
         pos = W'(sum);
         if (!any && req[pos]) begin
            any      = 1'b1;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin arbiter feeding NDATA-word packets into an external PISO register; grant/load same cycle as request in IDLE.
// One beat per i_ready handshake; i_ready low freezes the packet with o_valid held; one idle cycle between packets.
module ser_arbiter
   import ser_arbiter_pkg::*;
#(
   parameter int BIT   = 8,
   parameter int NDATA = 3,
   parameter int NREQ  = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   ser_arbiter_if.master bus
);

   localparam int SW = idx_width(NREQ);
   localparam int CW = idx_width(NDATA);

   if (BIT < 1 || NDATA < 1 || NREQ < 2) begin : g_bad_param
      $error("ser_arbiter: illegal parameter combination");
   end

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   ptr;
   logic [SW-1:0]   src;

   logic [NREQ-1:0] pick_gnt;
   logic [SW-1:0]   pick_idx;
   logic            pick_any;

   logic            granting;
   logic            sending;
   logic            is_last;

   rr_pick #(.N(NREQ), .W(SW)) u_pick (
      .req (bus.i_req),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Reset gates every strobe, since state only clears on the edge
   assign granting = !i_rst && (state == IDLE) && pick_any;
   assign sending  = !i_rst && (state == SEND);
   assign is_last  = (cnt == CW'(NDATA - 1));

   assign bus.o_gnt   = granting ? pick_gnt : '0;
   assign bus.o_load  = granting;
   assign bus.o_sel   = granting ? pick_idx : (sending ? src : '0);
   assign bus.o_valid = sending;
   assign bus.o_shift = sending && bus.i_ready;
   assign bus.o_last  = sending && is_last;
   assign bus.o_src   = i_rst ? '0 : src;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= '0;
         ptr   <= '0;
         src   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state <= SEND;
                  cnt   <= '0;
                  src   <= pick_idx;
                  ptr   <= (pick_idx == SW'(NREQ - 1)) ? '0 : pick_idx + SW'(1);
               end
            end
            SEND: begin
               if (bus.i_ready) begin
                  if (is_last) state <= IDLE;
                  else         cnt   <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ser_arbiter.sv
// Bench for ser_arbiter: NREQ=4/NDATA=3 main instance with a modelled PISO register, plus an NDATA=1 instance.
module tb_ser_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst1 = 1'b1;
   always #5 clk = ~clk;

   ser_arbiter_if #(.NREQ(4)) bus ();
   ser_arbiter_if #(.NREQ(4)) bus1 ();

   ser_arbiter #(.BIT(8), .NDATA(3), .NREQ(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   ser_arbiter #(.BIT(8), .NDATA(1), .NREQ(4)) dut1 (
      .i_clk (clk),
      .i_rst (rst1),
      .bus   (bus1)
   );

   int tests = 0;
   int fails = 0;

   // {gnt, load, sel, valid, shift, last, src}
   typedef struct packed {
      logic       rst;
      logic [3:0] req;
      logic       rdy;
      logic [13:0] exp;
   } vec_t;

   vec_t vec [19];

   function automatic vec_t mk(input logic r, input logic [3:0] q, input logic y,
                               input logic [3:0] g, input logic ld, input logic [1:0] sl,
                               input logic v, input logic sh, input logic la, input logic [1:0] sr);
      vec_t t;
      t.rst = r;
      t.req = q;
      t.rdy = y;
      t.exp = {g, ld, sl, v, sh, la, sr};
      return t;
   endfunction

   function automatic logic [13:0] obs_main();
      return {bus.o_gnt, bus.o_load, bus.o_sel, bus.o_valid, bus.o_shift, bus.o_last, bus.o_src};
   endfunction

   function automatic logic [13:0] obs_one();
      return {bus1.o_gnt, bus1.o_load, bus1.o_sel, bus1.o_valid, bus1.o_shift, bus1.o_last, bus1.o_src};
   endfunction

   function automatic logic [7:0] word(input int r, input int k);
      return 8'(r * 16 + k);
   endfunction

   // External parallel-in/serial-out register, head at preg[0]
   logic [7:0] preg [3];
   always @(posedge clk) begin
      if (bus.o_load) begin
         for (int k = 0; k < 3; k++) preg[k] <= word(int'(bus.o_sel), k);
      end else if (bus.o_shift) begin
         preg[0] <= preg[1];
         preg[1] <= preg[2];
         preg[2] <= 8'h00;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] q, input logic y);
      @(negedge clk);
      rst = r;
      bus.i_req = q;
      bus.i_ready = y;
      #1;
   endtask

   initial begin
      bus.i_req    = '0;
      bus.i_ready  = 1'b1;
      bus1.i_req   = '0;
      bus1.i_ready = 1'b1;

      //           rst   req      rdy   gnt      ld    sel    v     sh    last  src
      vec[0]  = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      vec[1]  = mk(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      vec[2]  = mk(1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
      vec[3]  = mk(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1);
      vec[4]  = mk(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1);
      vec[5]  = mk(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 2'd1);
      vec[6]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1);
      vec[7]  = mk(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1);
      vec[8]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2);
      vec[9]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 2'd2);
      vec[10] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 2'd2);
      vec[11] = mk(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2);
      vec[12] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
      vec[13] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
      vec[14] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
      vec[15] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0);
      vec[16] = mk(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
      vec[17] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      vec[18] = mk(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);

      for (int i = 0; i < 19; i++) begin
         drive(vec[i].rst, vec[i].req, vec[i].rdy);
         chk($sformatf("vec%0d", i), 32'(obs_main()), 32'(vec[i].exp));
      end

      // Fairness: all requesting, grant every 4th cycle in order 0,1,2,3,0
      drive(1'b1, 4'b0000, 1'b1);
      for (int c = 0; c < 20; c++) begin
         drive(1'b0, 4'b1111, 1'b1);
         if (c % 4 == 0) begin
            chk($sformatf("fair%0d gnt", c), 32'(bus.o_gnt), 32'(4'b0001 << ((c / 4) % 4)));
         end else begin
            chk($sformatf("fair%0d beat", c), 32'({bus.o_valid, bus.o_src, bus.o_last}),
                32'({1'b1, 2'((c / 4) % 4), (c % 4 == 3)}));
            chk($sformatf("fair%0d word", c), 32'(preg[0]), 32'(word((c / 4) % 4, c % 4 - 1)));
         end
      end

      // Backpressure on the second beat for 5 cycles
      drive(1'b1, 4'b0000, 1'b1);
      drive(1'b0, 4'b1000, 1'b1);
      chk("bp grant", 32'(obs_main()), 32'({4'b1000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0}));
      drive(1'b0, 4'b0000, 1'b1);
      chk("bp beat0", 32'({bus.o_valid, bus.o_shift, bus.o_last, preg[0]}), 32'({3'b110, 8'h30}));
      for (int s = 0; s < 5; s++) begin
         drive(1'b0, 4'b0000, 1'b0);
         chk($sformatf("bp stall%0d", s), 32'({bus.o_valid, bus.o_shift, bus.o_last, preg[0]}),
             32'({3'b100, 8'h31}));
      end
      drive(1'b0, 4'b0000, 1'b1);
      chk("bp beat1", 32'({bus.o_valid, bus.o_shift, bus.o_last, preg[0]}), 32'({3'b110, 8'h31}));
      drive(1'b0, 4'b0000, 1'b1);
      chk("bp beat2", 32'({bus.o_valid, bus.o_shift, bus.o_last, preg[0]}), 32'({3'b111, 8'h32}));
      drive(1'b0, 4'b0000, 1'b1);
      chk("bp idle", 32'({bus.o_valid, bus.o_shift, bus.o_load}), 32'(3'b000));

      // Single-word packets: first beat is also the last
      @(negedge clk);
      rst1 = 1'b0;
      bus1.i_req = 4'b0100;
      #1;
      chk("nd1 grant", 32'(obs_one()), 32'({4'b0100, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0}));
      @(negedge clk);
      bus1.i_req = 4'b0000;
      #1;
      chk("nd1 beat", 32'(obs_one()), 32'({4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 2'd2}));
      @(negedge clk);
      #1;
      chk("nd1 idle", 32'(obs_one()), 32'({4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2}));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
